// File: rtl/sum_byte_serializer.sv
// Buffers running-sum words in a small FIFO and emits them as byte_width beats, MS slice first.
// Optional byte_parity output is enabled by defining SUM_BYTE_SERIALIZER_PARITY_EN.
module sum_byte_serializer #(
    parameter int unsigned in_width   = 16,
    parameter int unsigned byte_width = 8,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in_valid,
    input  logic [in_width-1:0]   data_in,
    input  logic                  byte_ready,
    output logic                  byte_valid,
    output logic [byte_width-1:0] byte_out,
    output logic                  fifo_full,
`ifdef SUM_BYTE_SERIALIZER_PARITY_EN
    output logic                  byte_parity,
`endif
    output logic                  overflow
);

    localparam int unsigned Beats = in_width / byte_width;
    localparam int unsigned PtrW  = $clog2(fifo_depth);
    localparam int unsigned OccW  = PtrW + 1;
    localparam int unsigned CntW  = $clog2(Beats + 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                state_q;
    logic [in_width-1:0]   mem_q [fifo_depth];
    logic [PtrW-1:0]       rd_ptr_q;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [OccW-1:0]       occ_q;
    logic [in_width-1:0]   shift_q;
    logic [CntW-1:0]       beat_cnt_q;
    logic                  byte_valid_q;
    logic                  overflow_q;

    logic                  fifo_empty;
    logic                  fifo_full_int;
    logic                  beat_xfer;
    logic                  last_beat;
    logic                  pop;
    logic                  push;
    logic                  drop;

    always_comb begin
        fifo_empty    = (occ_q == '0);
        fifo_full_int = (occ_q == OccW'(fifo_depth));
        beat_xfer     = (state_q == StSend) && byte_ready;
        last_beat     = beat_xfer && (beat_cnt_q == CntW'(1));
        // Refill on the final beat so consecutive words stream without a bubble.
        pop           = !fifo_empty && ((state_q == StIdle) || last_beat);
        push          = data_in_valid && (!fifo_full_int || pop);
        drop          = data_in_valid && fifo_full_int && !pop;
    end

    // FIFO storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            shift_q      <= '0;
            beat_cnt_q   <= '0;
            byte_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OccW'(1);
                2'b01:   occ_q <= occ_q - OccW'(1);
                default: ;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q      <= mem_q[rd_ptr_q];
                        beat_cnt_q   <= CntW'(Beats);
                        byte_valid_q <= 1'b1;
                        state_q      <= StSend;
                    end
                end
                StSend: begin
                    if (last_beat) begin
                        if (pop) begin
                            shift_q    <= mem_q[rd_ptr_q];
                            beat_cnt_q <= CntW'(Beats);
                        end else begin
                            shift_q      <= '0;
                            beat_cnt_q   <= '0;
                            byte_valid_q <= 1'b0;
                            state_q      <= StIdle;
                        end
                    end else if (beat_xfer) begin
                        shift_q    <= shift_q << byte_width;
                        beat_cnt_q <= beat_cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // shift_q is cleared whenever the FSM is idle, so the top slice reads 0 there.
    assign byte_out   = shift_q[in_width-1 -: byte_width];
    assign byte_valid = byte_valid_q;
    assign fifo_full  = fifo_full_int;
    assign overflow   = overflow_q;

`ifdef SUM_BYTE_SERIALIZER_PARITY_EN
    assign byte_parity = ^byte_out;
`endif

endmodule

// File: tb/tb_sum_byte_serializer.sv
// Scoreboard bench for sum_byte_serializer: stimulus queues expected beats, a monitor checks them.
module tb_sum_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_in_valid;
    logic [15:0] data_in;
    logic        byte_ready;
    logic        byte_valid;
    logic [7:0]  byte_out;
    logic        fifo_full;
    logic        overflow;
`ifdef SUM_BYTE_SERIALIZER_PARITY_EN
    logic        byte_parity;
`endif

    int          total = 0;
    int          bad   = 0;
    int          beats = 0;
    logic [7:0]  sb [$];
    logic [7:0]  exp_b;

    always #5 clk = ~clk;

    sum_byte_serializer #(
        .in_width   (16),
        .byte_width (8),
        .fifo_depth (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .byte_ready    (byte_ready),
        .byte_valid    (byte_valid),
        .byte_out      (byte_out),
        .fifo_full     (fifo_full),
`ifdef SUM_BYTE_SERIALIZER_PARITY_EN
        .byte_parity   (byte_parity),
`endif
        .overflow      (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] w);
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
    endtask

    // Bounded wait until every queued beat has been taken and the DUT is idle.
    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (sb.size() == 0 && !byte_valid) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: got still busy (%0d queued) want idle", name, sb.size());
        end
    endtask

    // Monitor: a beat is taken on the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (byte_valid && byte_ready) begin
            beats++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got beat %0h want none", byte_out);
            end else begin
                exp_b = sb.pop_front();
                check("sb_beat", {24'h0, byte_out}, {24'h0, exp_b});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ow [6];
        int          hi;
        int          rises;
        int          beats0;
        logic        prev;

        rst           = 1'b1;
        data_in_valid = 1'b0;
        data_in       = 16'h0;
        byte_ready    = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", byte_valid, 0);
        check("rst_out", byte_out, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", overflow, 0);
`ifdef SUM_BYTE_SERIALIZER_PARITY_EN
        check("rst_parity", byte_parity, 0);
`endif

        // Single word, first beat one edge after the push.
        byte_ready    = 1'b1;
        data_in       = 16'h1234;
        data_in_valid = 1'b1;
        expect_word(16'h1234);
        step();
        data_in_valid = 1'b0;
        check("single_lat0", byte_valid, 0);
        step();
        check("single_lat1", byte_valid, 1);
        check("single_b0", byte_out, 8'h12);
        drain("single_drain");
        check("single_idle_out", byte_out, 0);

        // Stall: first beat held while ready is low.
        byte_ready    = 1'b0;
        data_in       = 16'hABCD;
        data_in_valid = 1'b1;
        expect_word(16'hABCD);
        step();
        data_in_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", byte_valid, 1);
            check("stall_out", byte_out, 8'hAB);
            step();
        end
        byte_ready = 1'b1;
        drain("stall_drain");

        // Back-to-back words stream with no gap.
        hi    = 0;
        rises = 0;
        prev  = 1'b0;
        ow[0] = 16'h0001;
        ow[1] = 16'h0203;
        ow[2] = 16'h0405;
        for (int k = 0; k < 3; k++) begin
            data_in       = ow[k];
            data_in_valid = 1'b1;
            expect_word(ow[k]);
            step();
            if (byte_valid) hi++;
            if (byte_valid && !prev) rises++;
            prev = byte_valid;
        end
        data_in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (byte_valid) hi++;
            if (byte_valid && !prev) rises++;
            prev = byte_valid;
        end
        check("b2b_valid_cycles", hi, 6);
        check("b2b_bursts", rises, 1);

        // Overflow: five words fit (four in FIFO, one in the shift register), sixth drops.
        byte_ready = 1'b0;
        ow[0] = 16'h1011;
        ow[1] = 16'h2021;
        ow[2] = 16'h3031;
        ow[3] = 16'h4041;
        ow[4] = 16'h5051;
        ow[5] = 16'h6061;
        for (int k = 0; k < 6; k++) begin
            data_in       = ow[k];
            data_in_valid = 1'b1;
            if (k < 5) expect_word(ow[k]);
            step();
            if (k == 3) check("ovf_not_full", fifo_full, 0);
            if (k == 4) begin
                check("ovf_full", fifo_full, 1);
                check("ovf_not_yet", overflow, 0);
            end
            if (k == 5) check("ovf_set", overflow, 1);
        end
        data_in_valid = 1'b0;
        step();
        step();
        step();
        check("ovf_sticky", overflow, 1);
        check("ovf_full_hold", fifo_full, 1);
        beats0     = beats;
        byte_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_beat_count", beats - beats0, 10);
        check("ovf_sticky_after", overflow, 1);
        check("ovf_full_clear", fifo_full, 0);

        // Reset mid-word: 0x12 taken, then reset while 0x34 is presented.
        data_in       = 16'h1234;
        data_in_valid = 1'b1;
        sb.push_back(8'h12);
        step();
        data_in_valid = 1'b0;
        step();
        step();
        byte_ready = 1'b0;
        check("mid_second_beat", byte_out, 8'h34);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", byte_valid, 0);
        check("mid_rst_out", byte_out, 0);
        check("mid_rst_full", fifo_full, 0);
        check("mid_rst_ovf", overflow, 0);
        step();
        check("mid_rst_stays_idle", byte_valid, 0);
        byte_ready    = 1'b1;
        data_in       = 16'h5678;
        data_in_valid = 1'b1;
        expect_word(16'h5678);
        step();
        data_in_valid = 1'b0;
        check("post_rst_lat0", byte_valid, 0);
        step();
        check("post_rst_b0", byte_out, 8'h56);
        drain("post_rst_drain");

`ifdef SUM_BYTE_SERIALIZER_PARITY_EN
        byte_ready    = 1'b0;
        data_in       = 16'h0703;
        data_in_valid = 1'b1;
        expect_word(16'h0703);
        step();
        data_in_valid = 1'b0;
        step();
        check("par_b0_out", byte_out, 8'h07);
        check("par_b0", byte_parity, 1);
        byte_ready = 1'b1;
        step();
        check("par_b1_out", byte_out, 8'h03);
        check("par_b1", byte_parity, 0);
        drain("par_drain");
        check("par_idle", byte_parity, 0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_byte_serializer.md
SUM_BYTE_SERIALIZER -- requirements
Module: sum_byte_serializer

Interface
REQ-001 The module SHALL have parameter in_width, default 16, meaning the width of the running-sum word accepted per valid.
REQ-002 The module SHALL have parameter byte_width, default 8, meaning the width of each output beat; in_width SHALL be an integer multiple of byte_width.
REQ-003 The module SHALL have parameter fifo_depth, default 4, meaning the number of input words buffered (power of two, at least 2).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 The module SHALL have port data_in_valid, input, 1 bit, a one-cycle qualifier for data_in, driven by the running-sum stage's data_out_valid.
REQ-007 The module SHALL have port data_in, input, in_width bits, the running-sum word.
REQ-008 The module SHALL have port byte_ready, input, 1 bit, the downstream acceptance signal.
REQ-009 The module SHALL have port byte_valid, output, 1 bit, indicating that byte_out holds a beat.
REQ-010 The module SHALL have port byte_out, output, byte_width bits, the current beat, most significant slice first.
REQ-011 The module SHALL have port fifo_full, output, 1 bit, high when the FIFO holds fifo_depth words.
REQ-012 The module SHALL have port overflow, output, 1 bit, a sticky dropped-word flag.

Function
REQ-013 The module SHALL push data_in into the FIFO on a clock edge where data_in_valid=1 and the FIFO is not full or a pop occurs on the same edge.
REQ-014 The module SHALL drop the word and set overflow=1 when data_in_valid=1, the FIFO is full and no pop occurs on that edge; overflow SHALL hold 1 until rst.
REQ-015 The FSM SHALL have two states: IDLE, with byte_valid=0, and SEND, with byte_valid=1.
REQ-016 In IDLE with the FIFO non-empty, the module SHALL pop the head word into the shift register, load beat count = in_width/byte_width, and enter SEND.
REQ-017 In SEND, a beat transfers only on an edge with byte_valid=1 and byte_ready=1; the module SHALL then shift the register left by byte_width and decrement the count.
REQ-018 In SEND with byte_ready=0, byte_out and the state SHALL hold unchanged for any number of cycles.
REQ-019 On transfer of the last beat, the module SHALL pop the next word on the same edge and remain in SEND if the FIFO is non-empty, with no idle bubble; otherwise it SHALL return to IDLE.
REQ-020 Latency: a word pushed at edge E0 into an empty FIFO while in IDLE SHALL have its first beat valid immediately after edge E1.
REQ-021 The FIFO read and write pointers SHALL wrap modulo fifo_depth; an occupancy counter of width log2(fifo_depth)+1 SHALL track full and empty.
REQ-022 Total buffering SHALL be fifo_depth words plus one word in the shift register.
REQ-023 byte_out SHALL equal the top byte_width bits of the shift register, and SHALL be 0 in IDLE.

Reset
REQ-024 When rst=1 at a clock edge, the module SHALL clear state to IDLE, the FIFO pointers and occupancy to 0, and the shift register and count to 0; byte_valid, byte_out, fifo_full and overflow SHALL all be 0 afterwards.
REQ-025 rst SHALL override any simultaneous push, pop or beat transfer, and SHALL abandon a word mid-serialisation.

Configuration
REQ-026 With macro SUM_BYTE_SERIALIZER_PARITY_EN defined, the module SHALL add output port byte_parity, 1 bit, equal to the even parity (XOR reduction) of byte_out, and 0 in reset or IDLE.
REQ-027 Without SUM_BYTE_SERIALIZER_PARITY_EN, the byte_parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover a single word: rst, then data_in=0x1234 for one cycle with byte_ready=1 -> byte_valid first seen one edge after the push, beats 0x12 then 0x34, then byte_valid=0.
REQ-029 The bench SHALL cover a stall: 0xABCD with byte_ready=0 for 5 cycles -> byte_out stays 0xAB with byte_valid=1; after ready rises, 0xCD follows.
REQ-030 The bench SHALL cover back-to-back words: 0x0001, 0x0203, 0x0405 on consecutive cycles with byte_ready=1 -> beats 00,01,02,03,04,05 on 6 consecutive edges with no gap.
REQ-031 The bench SHALL cover overflow: byte_ready=0, with 6 words pushed -> words 1-5 accepted, fifo_full=1 after the 5th, 6th dropped, overflow=1 and sticky; on releasing ready, exactly 10 beats emerge in order.
REQ-032 The bench SHALL cover reset mid-word: rst asserted after beat 0x12 of 0x1234 -> no 0x34 beat; all outputs 0; next word 0x5678 serialises normally.
REQ-033 The bench SHALL cover parity with SUM_BYTE_SERIALIZER_PARITY_EN defined: word 0x0703 -> byte_parity=1 for 0x07 and 0 for 0x03.
